nth_root_fxp: RTL and testbench
===============================

# nth_root_fxp

Parametrised, handshaked fixed-point n-th root engine for the arithmetic datapath. It accepts an unsigned integer radicand and an integer exponent, and returns the root as an unsigned Q(IW).(FW) value. The root is computed bit-serially, MSB first, by trial squaring/powering with one shared multiplier. It is the generalised successor of the fixed Q10.10 root unit and adds the following:
- configurable widths,
- in/out valid-ready flow control,
- an error flag for a zero exponent,
- early-reject rules that remain correct for sub-unity candidates.

## Interface
Parameters:
- IW, 10: radicand width, equal to the result integer bits
- FW, 10: result fraction bits
- EW, 3: exponent width; maximum exponent is 2^EW-1
- Derived: RW = IW+FW is the result width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  engine idle, can accept a request
- in_radicand  in  IW  unsigned integer radicand A
- in_exp  in  EW  exponent n
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts the result
- out_data  out  RW  root, unsigned Q(IW).(FW)
- out_err  out  1  set when n==0

## Operation
- States are IDLE, TRY, MUL and DONE.
- On reset: state=IDLE, in_ready=1, out_valid=0, out_data=0, out_err=0. All internal registers are cleared.
- **IDLE**
  - in_ready=1.
  - On in_valid, latch A as R = A<<FW (RW bits) and latch n. Then branch on n:
    - n==0: out_data=0, out_err=1, go to DONE.
    - n==1: out_data=R, go to DONE.
    - otherwise: res=0, bit=RW-1, go to TRY.
- **TRY**
  - cand = res | (1<<bit); acc = cand; cnt = 1; go to MUL.
- **MUL** (one multiply per cycle)
  - p = (acc*cand)>>FW, truncated, computed at 2*RW width before the shift.
  - If cnt==n-1 (final product):
    - p <= R: accept, res |= 1<<bit.
    - p == R: also terminate early.
  - Else, if p > R and cand >= 1.0 (integer part nonzero): reject early. Later products cannot decrease, so rejection is safe.
  - Else: acc = p, cnt++, stay in MUL.
  - A decision (accept or reject) on bit 0, or an exact match, goes to DONE. Any other decision goes to TRY with bit-1.
  - When cand < 1.0, never reject early. Products shrink, so all n-1 multiplies run.
- **DONE**
  - out_valid=1; out_data=res (or the n==0/n==1 value); out_err as set.
  - On out_valid&&out_ready: go to IDLE and clear out_valid, out_data and out_err.
- Result: the largest RW-bit x whose truncated, iterated power is <= R. Truncation applies after every multiply, matching hardware.
- A radicand of 0 gives 0 for every n>=1.

## Timing
- Handshakes:
  - A request is accepted on the edge where in_valid&&in_ready.
  - Input fields are sampled only at that edge and may change afterwards.
  - in_ready=0 from the cycle after acceptance until the engine returns to IDLE.
- Latency from acceptance edge to out_valid high:
  - n=0 or n=1: 1 cycle.
  - n>=2: sum over RW bits of (1 TRY + m_b MUL cycles) + 1, where 1 <= m_b <= n-1.
  - Worst case: RW*n+1 cycles, i.e. 41 cycles for defaults and n=2.
  - Exact match or early reject shortens latency.
- Backpressure: out_valid, out_data and out_err stay stable while out_ready=0. Throughput is one request at a time, with no overlap.
- rst_n low at any clock edge, including mid-MUL or in DONE: the operation is aborted and all state returns to its reset value on that edge. A pending result is discarded.
- in_valid while busy is ignored, not queued.

## Structure
- Package nth_root_pkg holds:
  - the state enum (IDLE/TRY/MUL/DONE),
  - a helper function for RW,
  - default width constants.
- Sub-module fxp_mul_trunc: a combinational RW×RW multiply with >>FW truncation, parametrised on RW and FW. It is the only multiplier and is shared by every MUL cycle.
- The top level holds:
  - the FSM,
  - the bit/cnt counters,
  - the res/acc/cand registers,
  - the comparator against R.

## Test plan
Defaults apply throughout: IW=10, FW=10, EW=3.
- A=4, n=2 -> out_data=0x00800 (2.0), out_err=0. Exact-match early exit: latency < 41.
- A=2, n=2 -> out_data=0x005A8 (1448/1024). 1449 is rejected because trunc(1449²>>10)=2050 > 2048.
- A=27, n=3 -> 0x00C00. A=1023, n=1 -> 0xFFC00 after 1 cycle. A=0, n=7 -> 0x00000.
- A=5, n=0 -> out_err=1, out_data=0, 1-cycle latency.
- Backpressure and overlap: hold out_ready=0 for 10 cycles; out_valid/out_data stay stable and in_ready stays 0. A second in_valid during busy is ignored. The next request is accepted only after the output handshake.
- Reset mid-operation: assert rst_n=0 during MUL of A=1000, n=5. All outputs return to reset values next edge. A following A=32, n=5 returns 0x00800.

Source files
------------

// File: rtl/nth_root_pkg.sv
// Shared types and defaults for the fixed-point n-th root engine.
// No logic: state encoding, width helper and default widths only.
// Imported by the engine top level.
package nth_root_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRY  = 2'd1,
    MUL  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_IW = 10;
  localparam int DEF_FW = 10;
  localparam int DEF_EW = 3;

  // Result width: integer bits plus fraction bits.
  function automatic int calc_rw(input int iw, input int fw);
    return iw + fw;
  endfunction

endpackage

// File: rtl/fxp_mul_trunc.sv
// Unsigned RW x RW fixed-point multiply, product truncated by FW fraction bits.
// Latency: combinational.
// Backpressure: none; a pure function of its operands.
module fxp_mul_trunc #(
  parameter int RW = 20,
  parameter int FW = 10,
  localparam int PW = 2 * RW - FW
) (
  input  logic [RW-1:0] a,
  input  logic [RW-1:0] b,
  output logic [PW-1:0] p
);

  logic [2*RW-1:0] full;

  // The full-width product is kept, so a large trial power can never wrap
  // into a small value and be wrongly accepted.
  assign full = {{RW{1'b0}}, a} * {{RW{1'b0}}, b};
  assign p    = PW'(full >> FW);

endmodule

// File: rtl/nth_root_fxp.sv
// Bit-serial fixed-point n-th root: MSB-first trial powering on one shared multiplier.
// Latency: 1 cycle for n<=1 or A==0, otherwise at most RW*n+1 cycles from acceptance.
// Backpressure: in_ready low while busy; the result holds stable until out_ready.
module nth_root_fxp
  import nth_root_pkg::*;
#(
  parameter int IW = DEF_IW,
  parameter int FW = DEF_FW,
  parameter int EW = DEF_EW,
  localparam int RW = calc_rw(IW, FW)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_radicand,
  input  logic [EW-1:0] in_exp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic          out_err
);

  localparam int BW = $clog2(RW);
  localparam int PW = 2 * RW - FW;
  localparam logic [BW-1:0] TOP_BIT = BW'(RW - 1);
  localparam logic [RW-1:0] ONE     = RW'(1) << FW;

  state_t          state;
  logic [RW-1:0]   r_val;
  logic [RW-1:0]   res;
  logic [RW-1:0]   acc;
  logic [RW-1:0]   cand;
  logic [EW-1:0]   n_val;
  logic [EW-1:0]   cnt;
  logic [BW-1:0]   bit_idx;

  logic [PW-1:0]   p;
  logic [RW-1:0]   mask;
  logic            p_le;
  logic            p_eq;
  logic            last_mul;
  logic            decide;
  logic            accept;
  logic            finish;

  fxp_mul_trunc #(.RW(RW), .FW(FW)) u_mul (
    .a (acc),
    .b (cand),
    .p (p)
  );

  // Decision logic for the current MUL cycle. Early reject is only safe when
  // the candidate is >= 1.0; below 1.0 the products shrink, so all n-1
  // multiplies must run before the verdict.
  always_comb begin
    mask     = RW'(1) << bit_idx;
    p_le     = (p <= PW'(r_val));
    p_eq     = (p == PW'(r_val));
    last_mul = (cnt == n_val - EW'(1));
    decide   = last_mul || (!p_le && (cand >= ONE));
    accept   = last_mul && p_le;
    finish   = (accept && p_eq) || (bit_idx == '0);
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      r_val     <= '0;
      res       <= '0;
      acc       <= '0;
      cand      <= '0;
      n_val     <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r_val    <= RW'(in_radicand) << FW;
            n_val    <= in_exp;
            in_ready <= 1'b0;
            if (in_exp == '0) begin
              out_data <= '0;
              out_err  <= 1'b1;
              state    <= DONE;
            end else if (in_exp == EW'(1)) begin
              out_data <= RW'(in_radicand) << FW;
              state    <= DONE;
            end else if (in_radicand == '0) begin
              // Tiny candidates truncate to a zero power, so a zero radicand
              // is answered directly rather than by the trial search.
              out_data <= '0;
              state    <= DONE;
            end else begin
              res     <= '0;
              bit_idx <= TOP_BIT;
              state   <= TRY;
            end
          end
        end
        TRY: begin
          cand  <= res | mask;
          acc   <= res | mask;
          cnt   <= EW'(1);
          state <= MUL;
        end
        MUL: begin
          if (decide) begin
            if (accept) res <= res | mask;
            if (finish) begin
              out_data <= accept ? (res | mask) : res;
              state    <= DONE;
            end else begin
              bit_idx <= bit_idx - BW'(1);
              state   <= TRY;
            end
          end else begin
            acc <= p[RW-1:0];
            cnt <= cnt + EW'(1);
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nth_root_fxp.sv
// Directed bench for nth_root_fxp with hand-computed roots and latencies.
// Drives and samples 1 time unit after the rising edge.
// Exercises backpressure, busy-time requests and mid-operation reset.
module tb_nth_root_fxp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_radicand;
  logic [2:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_data;
  logic        out_err;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  nth_root_fxp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_radicand (in_radicand),
    .in_exp      (in_exp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_err     (out_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request on an edge where in_ready is high.
  task automatic start_req(input logic [9:0] a, input logic [2:0] n);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_radicand = a;
    in_exp      = n;
    in_valid    = 1'b1;
    tick();
    in_valid    = 1'b0;
    in_radicand = 10'h3A5;
    in_exp      = 3'd6;
  endtask

  // Cycles from the acceptance edge until out_valid is seen high.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run(input string tag, input logic [9:0] a, input logic [2:0] n,
                     input logic [19:0] exp_data, input logic exp_err, input int exp_lat);
    int lat;
    start_req(a, n);
    wait_valid(lat);
    check({tag, "_data"}, 32'(out_data), 32'(exp_data));
    check({tag, "_err"}, 32'(out_err), 32'(exp_err));
    if (exp_lat > 0) check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    drain();
  endtask

  initial begin
    int lat;
    logic saw_valid;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_radicand = '0;
    in_exp      = '0;
    out_ready   = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors: tag, A, n, expected root, expected err, expected latency.
    run("sqrt4",    10'd4,    3'd2, 20'h00800, 1'b0, 19);
    run("sqrt2",    10'd2,    3'd2, 20'h005A8, 1'b0, 41);
    run("cbrt27",   10'd27,   3'd3, 20'h00C00, 1'b0, 24);
    run("n1_1023",  10'd1023, 3'd1, 20'hFFC00, 1'b0, 1);
    run("zero_n7",  10'd0,    3'd7, 20'h00000, 1'b0, 0);
    run("n0_err",   10'd5,    3'd0, 20'h00000, 1'b1, 1);

    // Backpressure with a competing request held during the busy period.
    start_req(10'd27, 3'd3);
    in_radicand = 10'd5;
    in_exp      = 3'd0;
    in_valid    = 1'b1;
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h00C00);
      check("bp_err", 32'(out_err), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_out_valid", 32'(out_valid), 32'd0);
    check("hs_in_ready", 32'(in_ready), 32'd1);
    // The held request is accepted on this edge and returns the n==0 error.
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("held_req_err", 32'(out_err), 32'd1);
    check("held_req_data", 32'(out_data), 32'd0);
    check("held_req_lat", 32'(lat), 32'd1);
    drain();

    // Reset while the engine is in the middle of its search.
    start_req(10'd1000, 3'd5);
    tick();
    tick();
    tick();
    check("pre_rst_busy", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("aborted_no_result", 32'(saw_valid), 32'd0);
    run("root5_32", 10'd32, 3'd5, 20'h00800, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
